// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns a single valid/ready request into a SETUP/ACCESS transfer
// and returns the result on a valid/ready response channel, with optional PREADY timeout.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [2:0]          prot_q, prot_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            prot_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    prot_d  = req_prot;
                    strb_d  = req_write ? req_wstrb : '0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A late PREADY on the final timeout cycle still completes normally.
                if (pready) begin
                    rdata_d = (write_q || pslverr) ? '0 : prdata;
                    err_d   = pslverr;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pstrb     = strb_q;
    assign pprot     = prot_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4): the APB slave is driven inline and
// responses are checked against a scoreboard queue filled when each request is issued.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rstn;
    logic              reqValid, reqReady, reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic [STRB_W-1:0] reqWstrb;
    logic [2:0]        reqProt;
    logic              rspValid, rspReady, rspErr;
    logic [DATA_W-1:0] rspRdata;
    logic              psel, penable, pwrite, pready, pslverr;
    logic [ADDR_W-1:0] paddr;
    logic [STRB_W-1:0] pstrb;
    logic [2:0]        pprot;
    logic [DATA_W-1:0] pwdata, prdata;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    rsp_t expQ[$];
    int   vectors = 0;
    int   fails   = 0;

    apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(reqValid), .req_ready(reqReady), .req_addr(reqAddr),
        .req_write(reqWrite), .req_wdata(reqWdata), .req_wstrb(reqWstrb),
        .req_prot(reqProt),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_rdata(rspRdata),
        .rsp_err(rspErr),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pstrb(pstrb), .pprot(pprot), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBus(input string tag, input logic sel, input logic en,
                            input logic [ADDR_W-1:0] addr, input logic wr,
                            input logic [STRB_W-1:0] strb);
        checkEq({tag, "_psel"}, psel, sel);
        checkEq({tag, "_penable"}, penable, en);
        checkEq({tag, "_paddr"}, paddr, addr);
        checkEq({tag, "_pwrite"}, pwrite, wr);
        checkEq({tag, "_pstrb"}, pstrb, strb);
        checkEq({tag, "_rsp_valid_low"}, rspValid, 1'b0);
    endtask

    // Drives one request at a negedge while the bridge is idle; returns at the SETUP negedge.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic wr,
                                 input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                                 input logic [2:0] prot);
        reqAddr  = addr;
        reqWrite = wr;
        reqWdata = wdata;
        reqWstrb = strb;
        reqProt  = prot;
        reqValid = 1'b1;
        checkEq("req_ready_idle", reqReady, 1'b1);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        rsp_t e;
        int   n = 0;
        while (rspValid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkEq({tag, "_rsp_valid"}, rspValid, 1'b1);
        if (rspValid === 1'b1) begin
            checkEq({tag, "_rsp_expected"}, expQ.size() > 0, 1'b1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkEq({tag, "_rsp_rdata"}, rspRdata, e.rdata);
                checkEq({tag, "_rsp_err"}, rspErr, e.err);
            end
        end
    endtask

    task automatic ackRsp(input string tag);
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkEq({tag, "_ack_rsp_valid"}, rspValid, 1'b0);
        checkEq({tag, "_ack_req_ready"}, reqReady, 1'b1);
        checkEq({tag, "_ack_rdata_clr"}, rspRdata, '0);
        checkEq({tag, "_ack_err_clr"}, rspErr, 1'b0);
    endtask

    initial begin
        rstn = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
        reqWstrb = '0; reqProt = '0; rspReady = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;

        #1 rstn = 1'b0;
        #1;
        checkEq("rst_req_ready", reqReady, 1'b1);
        checkEq("rst_outputs", {rspValid, psel, penable, pwrite, rspErr}, 5'b0);
        checkEq("rst_paddr", paddr, '0);
        checkEq("rst_pwdata", pwdata, '0);
        checkEq("rst_rdata", rspRdata, '0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] zero-wait write");
        pready = 1'b1; prdata = 32'hFFFF_FFFF;
        expQ.push_back('{rdata: '0, err: 1'b0});
        applyStimulus(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
        checkBus("t1_setup", 1'b1, 1'b0, 32'h1000_0004, 1'b1, 4'hF);
        checkEq("t1_pwdata", pwdata, 32'hDEAD_BEEF);
        checkEq("t1_pprot", pprot, 3'b010);
        checkEq("t1_req_ready_busy", reqReady, 1'b0);
        @(negedge clk);
        checkBus("t1_access", 1'b1, 1'b1, 32'h1000_0004, 1'b1, 4'hF);
        @(negedge clk);
        checkEq("t1_resp_psel", {psel, penable}, 2'b00);
        checkOutput("t1");
        ackRsp("t1");

        $display("[TB] wait-state read");
        pready = 1'b0; prdata = 32'h1234_5678;
        expQ.push_back('{rdata: 32'h1234_5678, err: 1'b0});
        applyStimulus(32'h1000_1008, 1'b0, 32'h0BAD_0BAD, 4'hF, 3'b001);
        checkBus("t2_setup", 1'b1, 1'b0, 32'h1000_1008, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBus($sformatf("t2_access%0d", i), 1'b1, 1'b1, 32'h1000_1008, 1'b0, 4'h0);
            if (i == 3) pready = 1'b1;
        end
        @(negedge clk);
        pready = 1'b0;
        checkEq("t2_resp_psel", {psel, penable}, 2'b00);
        checkOutput("t2");
        ackRsp("t2");

        $display("[TB] slave error read");
        pready = 1'b1; pslverr = 1'b1; prdata = '0;
        expQ.push_back('{rdata: '0, err: 1'b1});
        applyStimulus(32'h1000_2000, 1'b0, '0, 4'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        pslverr = 1'b0;
        checkOutput("t3");
        ackRsp("t3");

        $display("[TB] timeout abort");
        pready = 1'b0; prdata = 32'h7777_7777;
        expQ.push_back('{rdata: '0, err: 1'b1});
        applyStimulus(32'h1000_3000, 1'b0, '0, 4'h0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBus($sformatf("t4a_access%0d", i), 1'b1, 1'b1, 32'h1000_3000, 1'b0, 4'h0);
        end
        @(negedge clk);
        checkEq("t4a_abort_psel", {psel, penable}, 2'b00);
        checkOutput("t4a");
        ackRsp("t4a");

        $display("[TB] pready on final timeout cycle");
        prdata = 32'hCAFE_F00D;
        expQ.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
        applyStimulus(32'h1000_3004, 1'b0, '0, 4'h0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq($sformatf("t4b_penable%0d", i), penable, 1'b1);
            if (i == 3) pready = 1'b1;
        end
        @(negedge clk);
        pready = 1'b0;
        checkOutput("t4b");
        ackRsp("t4b");

        $display("[TB] response backpressure with pending request");
        pready = 1'b1; prdata = '0;
        expQ.push_back('{rdata: '0, err: 1'b0});
        applyStimulus(32'h1000_4000, 1'b1, 32'hA5A5_A5A5, 4'h3, 3'b000);
        @(negedge clk);
        @(negedge clk);
        reqValid = 1'b1; reqAddr = 32'h1000_5000; reqWrite = 1'b0; reqWstrb = 4'hF;
        checkOutput("t5a");
        for (int i = 0; i < 5; i++) begin
            checkEq($sformatf("t5_hold_valid%0d", i), rspValid, 1'b1);
            checkEq($sformatf("t5_hold_err%0d", i), rspErr, 1'b0);
            checkEq($sformatf("t5_hold_req_ready%0d", i), reqReady, 1'b0);
            checkEq($sformatf("t5_hold_psel%0d", i), psel, 1'b0);
            checkEq($sformatf("t5_hold_paddr%0d", i), paddr, 32'h1000_4000);
            @(negedge clk);
        end
        prdata = 32'h5555_AAAA;
        expQ.push_back('{rdata: 32'h5555_AAAA, err: 1'b0});
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checkEq("t5_idle_rsp_valid", rspValid, 1'b0);
        checkEq("t5_idle_req_ready", reqReady, 1'b1);
        checkEq("t5_idle_psel", psel, 1'b0);
        @(negedge clk);
        reqValid = 1'b0;
        checkBus("t5b_setup", 1'b1, 1'b0, 32'h1000_5000, 1'b0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5b");
        ackRsp("t5b");

        $display("[TB] reset during access");
        pready = 1'b0; prdata = 32'h9999_9999;
        applyStimulus(32'h1000_6000, 1'b1, 32'h1111_2222, 4'hF, 3'b111);
        @(negedge clk);
        checkEq("t6_in_access", penable, 1'b1);
        rstn = 1'b0;
        #1;
        checkEq("t6_rst_req_ready", reqReady, 1'b1);
        checkEq("t6_rst_ctrl", {rspValid, psel, penable, pwrite, rspErr}, 5'b0);
        checkEq("t6_rst_paddr", paddr, '0);
        checkEq("t6_rst_pstrb_pprot", {pstrb, pprot}, '0);
        checkEq("t6_rst_pwdata", pwdata, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkEq("t6_no_rsp", rspValid, 1'b0);
        pready = 1'b1;
        expQ.push_back('{rdata: '0, err: 1'b0});
        applyStimulus(32'h1000_7000, 1'b1, 32'h3333_4444, 4'hC, 3'b000);
        checkBus("t6_setup", 1'b1, 1'b0, 32'h1000_7000, 1'b1, 4'hC);
        checkOutput("t6");
        ackRsp("t6");

        checkEq("scoreboard_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
